// File: rtl/match_judge_if.sv
// Player handshake and result bus for the match judge.
// master: judge side (drives ready/result/status); slave: players and scorer.
interface match_judge_if;
   logic       start;
   logic       p1_valid;
   logic [1:0] p1_choice;
   logic       p1_ready;
   logic       p2_valid;
   logic [1:0] p2_choice;
   logic       p2_ready;
   logic [1:0] matchresult;
   logic       result_valid;
   logic [3:0] round_no;
   logic [3:0] p1_wins;
   logic [3:0] p2_wins;
   logic       game_over;
   logic [1:0] winner;
   logic       busy;

   modport master (
      input  start, p1_valid, p1_choice, p2_valid, p2_choice,
      output p1_ready, p2_ready, matchresult, result_valid,
      output round_no, p1_wins, p2_wins, game_over, winner, busy
   );

   modport slave (
      output start, p1_valid, p1_choice, p2_valid, p2_choice,
      input  p1_ready, p2_ready, matchresult, result_valid,
      input  round_no, p1_wins, p2_wins, game_over, winner, busy
   );
endinterface

// File: rtl/match_judge.sv
// Rock/paper/scissors judge: collects two hidden choices, emits a result pulse.
// Ports: clk, resetn (async low), bus (match_judge_if.master). Macro MATCH_JUDGE_TIMEOUT_EN adds a forfeit timeout.
module match_judge #(
   parameter int WIN_TARGET     = 3,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = 10
) (
   input  logic          clk,
   input  logic          resetn,
   match_judge_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_JUDGE,
      S_REPORT,
      S_OVER
   } state_t;

   localparam logic [1:0] ROCK  = 2'b01;
   localparam logic [1:0] PAPER = 2'b10;
   localparam logic [1:0] SCIS  = 2'b11;
   localparam logic [3:0] TGT   = 4'(WIN_TARGET);

   if (WIN_TARGET < 1 || WIN_TARGET > 15 ||
       TIMEOUT_CYCLES < 1 ||
       TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_cfg
      $error("match_judge: illegal parameter set");
   end

   state_t     state, state_nx;
   logic [1:0] c1, c2;
   logic       h1, h2;
   logic [1:0] res_q;
   logic [3:0] rnd, w1, w2;
   logic [1:0] win_q;
   logic       take1, take2;
   logic       to_fire;
   logic [1:0] verdict;

   function automatic logic [1:0] judge(input logic [1:0] a,
                                        input logic [1:0] b);
      logic p1_beats;
      p1_beats = (a == ROCK  && b == SCIS)  ||
                 (a == SCIS  && b == PAPER) ||
                 (a == PAPER && b == ROCK);
      if (a == b)
         return 2'b01;
      return p1_beats ? 2'b10 : 2'b11;
   endfunction

   assign take1 = (state == S_COLLECT) && !h1 &&
                  bus.p1_valid && (bus.p1_choice != 2'b00);
   assign take2 = (state == S_COLLECT) && !h2 &&
                  bus.p2_valid && (bus.p2_choice != 2'b00);

   // With only one choice held the round can only reach JUDGE by forfeit.
   always_comb begin
      verdict = 2'b11;
      if (h1 && h2)
         verdict = judge(c1, c2);
      else if (h1)
         verdict = 2'b10;
   end

`ifdef MATCH_JUDGE_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] to_cnt;
   logic            to_hit;

   assign to_hit  = (state == S_COLLECT) && !bus.start &&
                    !(h1 && h2) && (to_cnt == TO_LIM);
   // A capture landing on the limit edge wins over the forfeit.
   assign to_fire = to_hit && (h1 ^ h2) && !take1 && !take2;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         to_cnt <= '0;
      else if (bus.start || state != S_COLLECT)
         to_cnt <= '0;
      else if ((h1 && h2) || (h1 && take2) ||
               (h2 && take1) || (take1 && take2))
         to_cnt <= '0;
      else if (to_hit)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign to_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:
            if (bus.start)
               state_nx = S_COLLECT;
         S_COLLECT:
            if (bus.start)
               state_nx = S_COLLECT;
            else if ((h1 && h2) || to_fire)
               state_nx = S_JUDGE;
         S_JUDGE:
            state_nx = bus.start ? S_COLLECT : S_REPORT;
         S_REPORT:
            if (!bus.start && (w1 == TGT || w2 == TGT))
               state_nx = S_OVER;
            else
               state_nx = S_COLLECT;
         S_OVER:
            if (bus.start)
               state_nx = S_COLLECT;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         c1    <= '0;
         c2    <= '0;
         h1    <= 1'b0;
         h2    <= 1'b0;
         res_q <= '0;
         rnd   <= '0;
         w1    <= '0;
         w2    <= '0;
         win_q <= '0;
      end else if (bus.start) begin
         c1    <= '0;
         c2    <= '0;
         h1    <= 1'b0;
         h2    <= 1'b0;
         res_q <= '0;
         rnd   <= '0;
         w1    <= '0;
         w2    <= '0;
         win_q <= '0;
      end else begin
         case (state)
            S_COLLECT: begin
               if (take1) begin
                  c1 <= bus.p1_choice;
                  h1 <= 1'b1;
               end
               if (take2) begin
                  c2 <= bus.p2_choice;
                  h2 <= 1'b1;
               end
            end
            S_JUDGE: begin
               res_q <= verdict;
               rnd   <= rnd + 1'b1;
               if (verdict == 2'b10)
                  w1 <= w1 + 1'b1;
               if (verdict == 2'b11)
                  w2 <= w2 + 1'b1;
            end
            S_REPORT: begin
               res_q <= '0;
               c1    <= '0;
               c2    <= '0;
               h1    <= 1'b0;
               h2    <= 1'b0;
               if (w1 == TGT)
                  win_q <= 2'b01;
               else if (w2 == TGT)
                  win_q <= 2'b10;
            end
            default: ;
         endcase
      end
   end

   assign bus.p1_ready     = (state == S_COLLECT) && !h1;
   assign bus.p2_ready     = (state == S_COLLECT) && !h2;
   assign bus.matchresult  = res_q;
   assign bus.result_valid = (state == S_REPORT);
   assign bus.round_no     = rnd;
   assign bus.p1_wins      = w1;
   assign bus.p2_wins      = w2;
   assign bus.game_over    = (state == S_OVER);
   assign bus.winner       = win_q;
   assign bus.busy         = (state == S_COLLECT) ||
                             (state == S_JUDGE)   ||
                             (state == S_REPORT);

endmodule

// File: tb/tb_match_judge.sv
// Directed bench for match_judge: rounds, draws, game end, aborts, timeout.
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_match_judge;

   logic clk;
   logic resetn;
   int   cmp_n;
   int   bad_n;

   match_judge_if bus ();

   match_judge #(
      .WIN_TARGET    (3),
      .TIMEOUT_CYCLES(1000),
      .TO_W          (10)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.start     = 1'b0;
      bus.p1_valid  = 1'b0;
      bus.p1_choice = 2'b00;
      bus.p2_valid  = 1'b0;
      bus.p2_choice = 2'b00;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Both players commit together; returns in the REPORT cycle.
   task automatic play(input logic [1:0] a, input logic [1:0] b);
      bus.p1_valid  = 1'b1;
      bus.p1_choice = a;
      bus.p2_valid  = 1'b1;
      bus.p2_choice = b;
      tick();
      idle_in();
      tick();
      tick();
   endtask

   function automatic logic [24:0] outs();
      return {bus.p1_ready, bus.p2_ready, bus.matchresult,
              bus.result_valid, bus.round_no, bus.p1_wins,
              bus.p2_wins, bus.game_over, bus.winner, bus.busy};
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.start     = 1'($urandom_range(0, 1));
         bus.p1_valid  = 1'($urandom_range(0, 1));
         bus.p1_choice = 2'($urandom_range(0, 3));
         bus.p2_valid  = 1'($urandom_range(0, 1));
         bus.p2_choice = 2'($urandom_range(0, 3));
         tick();
         cmp_n++;
         if (outs() !== 25'd0) begin
            bad_n++;
            $display("FAIL reset_outs got %h want 0", outs());
         end
      end
      idle_in();
      resetn = 1'b1;
      tick();
      tick();
      cmp_n++;
      if ({bus.busy, bus.p1_ready, bus.game_over} !== 3'b000) begin
         bad_n++;
         $display("FAIL reset_idle got %b want 000",
                  {bus.busy, bus.p1_ready, bus.game_over});
      end
   endtask

   task automatic test_basic();
      do_start();
      cmp_n++;
      if ({bus.busy, bus.p1_ready, bus.p2_ready} !== 3'b111) begin
         bad_n++;
         $display("FAIL basic_collect got %b want 111",
                  {bus.busy, bus.p1_ready, bus.p2_ready});
      end
      bus.p1_valid  = 1'b1;
      bus.p1_choice = 2'b01;
      bus.p2_valid  = 1'b1;
      bus.p2_choice = 2'b11;
      tick();
      idle_in();
      tick();
      cmp_n++;
      if (bus.result_valid !== 1'b0) begin
         bad_n++;
         $display("FAIL basic_early got %b want 0", bus.result_valid);
      end
      tick();
      cmp_n++;
      if ({bus.result_valid, bus.matchresult, bus.round_no,
           bus.p1_wins, bus.p2_wins} !== {1'b1, 2'b10, 4'd1, 4'd1, 4'd0}) begin
         bad_n++;
         $display("FAIL basic_report got %b/%b/%0d/%0d/%0d want 1/10/1/1/0",
                  bus.result_valid, bus.matchresult, bus.round_no,
                  bus.p1_wins, bus.p2_wins);
      end
      tick();
      cmp_n++;
      if ({bus.result_valid, bus.matchresult} !== 3'b000) begin
         bad_n++;
         $display("FAIL basic_after got %b/%b want 0/00",
                  bus.result_valid, bus.matchresult);
      end
   endtask

   task automatic test_draw_invalid();
      bus.p1_valid  = 1'b1;
      bus.p1_choice = 2'b00;
      for (int i = 0; i < 5; i++) begin
         tick();
         cmp_n++;
         if (bus.p1_ready !== 1'b1) begin
            bad_n++;
            $display("FAIL invalid_ready got %b want 1", bus.p1_ready);
         end
      end
      bus.p1_choice = 2'b10;
      bus.p2_valid  = 1'b1;
      bus.p2_choice = 2'b10;
      tick();
      bus.p1_choice = 2'b01;
      bus.p2_valid  = 1'b0;
      cmp_n++;
      if ({bus.p1_ready, bus.p2_ready} !== 2'b00) begin
         bad_n++;
         $display("FAIL draw_ready got %b want 00",
                  {bus.p1_ready, bus.p2_ready});
      end
      tick();
      idle_in();
      tick();
      cmp_n++;
      if ({bus.result_valid, bus.matchresult, bus.round_no,
           bus.p1_wins, bus.p2_wins} !== {1'b1, 2'b01, 4'd2, 4'd1, 4'd0}) begin
         bad_n++;
         $display("FAIL draw_report got %b/%b/%0d/%0d/%0d want 1/01/2/1/0",
                  bus.result_valid, bus.matchresult, bus.round_no,
                  bus.p1_wins, bus.p2_wins);
      end
      tick();
   endtask

   task automatic test_game_end();
      do_start();
      for (int r = 1; r <= 3; r++) begin
         play(2'b01, 2'b10);
         cmp_n++;
         if ({bus.matchresult, bus.p2_wins} !== {2'b11, 4'(r)}) begin
            bad_n++;
            $display("FAIL end_round%0d got %b/%0d want 11/%0d",
                     r, bus.matchresult, bus.p2_wins, r);
         end
         tick();
      end
      cmp_n++;
      if ({bus.game_over, bus.winner, bus.p2_wins, bus.round_no,
           bus.p1_ready, bus.p2_ready, bus.busy} !==
          {1'b1, 2'b10, 4'd3, 4'd3, 3'b000}) begin
         bad_n++;
         $display("FAIL end_over got %b/%b/%0d/%0d/%b want 1/10/3/3/000",
                  bus.game_over, bus.winner, bus.p2_wins, bus.round_no,
                  {bus.p1_ready, bus.p2_ready, bus.busy});
      end
      bus.p1_valid  = 1'b1;
      bus.p1_choice = 2'b01;
      bus.p2_valid  = 1'b1;
      bus.p2_choice = 2'b11;
      tick();
      tick();
      idle_in();
      cmp_n++;
      if ({bus.game_over, bus.winner, bus.p1_wins, bus.p2_wins} !==
          {1'b1, 2'b10, 4'd0, 4'd3}) begin
         bad_n++;
         $display("FAIL end_hold got %b/%b/%0d/%0d want 1/10/0/3",
                  bus.game_over, bus.winner, bus.p1_wins, bus.p2_wins);
      end
      do_start();
      cmp_n++;
      if ({bus.game_over, bus.winner, bus.round_no, bus.p1_wins,
           bus.p2_wins, bus.busy, bus.p1_ready} !==
          {1'b0, 2'b00, 12'd0, 2'b11}) begin
         bad_n++;
         $display("FAIL end_restart got %b/%b/%0d/%0d/%0d/%b",
                  bus.game_over, bus.winner, bus.round_no, bus.p1_wins,
                  bus.p2_wins, {bus.busy, bus.p1_ready});
      end
   endtask

   task automatic test_abort_start();
      int seen;
      play(2'b11, 2'b10);
      tick();
      bus.p1_valid  = 1'b1;
      bus.p1_choice = 2'b01;
      tick();
      idle_in();
      cmp_n++;
      if ({bus.p1_ready, bus.p2_ready} !== 2'b01) begin
         bad_n++;
         $display("FAIL abort_half got %b want 01",
                  {bus.p1_ready, bus.p2_ready});
      end
      do_start();
      seen = 0;
      cmp_n++;
      if ({bus.p1_ready, bus.p2_ready, bus.round_no, bus.p1_wins,
           bus.p2_wins} !== {2'b11, 12'd0}) begin
         bad_n++;
         $display("FAIL abort_clear got %b/%0d/%0d/%0d want 11/0/0/0",
                  {bus.p1_ready, bus.p2_ready}, bus.round_no,
                  bus.p1_wins, bus.p2_wins);
      end
      for (int i = 0; i < 6; i++) begin
         if (bus.result_valid === 1'b1)
            seen++;
         tick();
      end
      cmp_n++;
      if (seen !== 0) begin
         bad_n++;
         $display("FAIL abort_strobe got %0d want 0", seen);
      end
   endtask

   task automatic test_start_in_report();
      play(2'b10, 2'b01);
      bus.start = 1'b1;
      #1;
      cmp_n++;
      if ({bus.result_valid, bus.matchresult, bus.p1_wins} !==
          {1'b1, 2'b10, 4'd1}) begin
         bad_n++;
         $display("FAIL rpt_start_strobe got %b/%b/%0d want 1/10/1",
                  bus.result_valid, bus.matchresult, bus.p1_wins);
      end
      tick();
      bus.start = 1'b0;
      cmp_n++;
      if ({bus.result_valid, bus.round_no, bus.p1_wins, bus.busy} !==
          {1'b0, 8'd0, 1'b1}) begin
         bad_n++;
         $display("FAIL rpt_start_clear got %b/%0d/%0d/%b want 0/0/0/1",
                  bus.result_valid, bus.round_no, bus.p1_wins, bus.busy);
      end
   endtask

   task automatic test_reset_in_judge();
      bus.p1_valid  = 1'b1;
      bus.p1_choice = 2'b01;
      bus.p2_valid  = 1'b1;
      bus.p2_choice = 2'b11;
      tick();
      idle_in();
      tick();
      #2;
      resetn = 1'b0;
      #1;
      cmp_n++;
      if (outs() !== 25'd0) begin
         bad_n++;
         $display("FAIL judge_reset got %h want 0", outs());
      end
      #1;
      resetn = 1'b1;
      tick();
      tick();
      cmp_n++;
      if ({bus.busy, bus.result_valid, bus.round_no} !== 6'd0) begin
         bad_n++;
         $display("FAIL judge_idle got %b/%b/%0d want 0/0/0",
                  bus.busy, bus.result_valid, bus.round_no);
      end
   endtask

   task automatic test_timeout();
      int n;
      logic got;
      do_start();
      bus.p1_valid  = 1'b1;
      bus.p1_choice = 2'b01;
      tick();
      idle_in();
      got = 1'b0;
`ifdef MATCH_JUDGE_TIMEOUT_EN
      n = 0;
      while (!got && n < 1100) begin
         if (bus.result_valid === 1'b1)
            got = 1'b1;
         else begin
            tick();
            n++;
         end
      end
      cmp_n++;
      if ({got, bus.matchresult, bus.p1_wins} !== {1'b1, 2'b10, 4'd1}) begin
         bad_n++;
         $display("FAIL timeout_forfeit got %b/%b/%0d want 1/10/1",
                  got, bus.matchresult, bus.p1_wins);
      end
`else
      n = 0;
      for (int i = 0; i < 5000; i++) begin
         if (bus.result_valid === 1'b1)
            got = 1'b1;
         tick();
         n++;
      end
      cmp_n++;
      if ({got, bus.p2_ready, bus.busy} !== 3'b011) begin
         bad_n++;
         $display("FAIL timeout_wait got %b/%b/%b want 0/1/1 after %0d",
                  got, bus.p2_ready, bus.busy, n);
      end
`endif
   endtask

   initial begin
      cmp_n = 0;
      bad_n = 0;
      idle_in();
      resetn = 1'b0;
      test_reset();
      test_basic();
      test_draw_invalid();
      test_game_end();
      test_abort_start();
      test_start_in_report();
      test_reset_in_judge();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp_n, bad_n);
      $finish;
   end

endmodule

// File: doc/match_judge.md
Name: match_judge

Overview:
- Producer side of the 2-bit `matchresult` interface consumed by the score-keeping block.
- Collects one hidden rock/paper/scissors choice from each player per round through a valid/ready handshake.
- Judges the round and emits a one-cycle result pulse.
- Tracks rounds and wins internally and declares game over when either player reaches WIN_TARGET wins.

Parameters:
- WIN_TARGET, 3: wins needed to end the game; legal range 1..15.
- TIMEOUT_CYCLES, 1000: COLLECT-state forfeit limit; used only with the optional feature.
- TO_W, 10: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  begin/restart game, sampled each cycle
- p1_valid  in  1  player 1 offers a choice
- p1_choice  in  2  01 rock, 10 paper, 11 scissors, 00 invalid
- p1_ready  out  1  player 1 choice can be accepted
- p2_valid  in  1  player 2 offers a choice
- p2_choice  in  2  same encoding as p1_choice
- p2_ready  out  1  player 2 choice can be accepted
- matchresult  out  2  00 none, 01 draw, 10 player 1 wins, 11 player 2 wins
- result_valid  out  1  one-cycle strobe qualifying matchresult
- round_no  out  4  rounds judged this game
- p1_wins  out  4  player 1 round wins
- p2_wins  out  4  player 2 round wins
- game_over  out  1  high while in GAMEOVER
- winner  out  2  00 none, 01 player 1, 10 player 2
- busy  out  1  high in COLLECT, JUDGE, REPORT

Behaviour:
- Reset:
  - resetn low asynchronously forces IDLE.
  - All outputs are 0; both ready outputs are low; captured choices are cleared.
  - Reset mid-round discards everything.
- IDLE -> COLLECT on start. All counters clear on that edge.
- COLLECT:
  - pN_ready = 1 until that player's choice is captured, then 0 for the rest of the round.
  - A choice is captured on an edge where pN_valid & pN_ready & (pN_choice != 00).
  - Choice 00 is never captured; ready stays high.
  - Players may commit in either order or in the same cycle.
  - Next state is JUDGE on the edge after both choices are held.
- JUDGE, one cycle:
  - Equal choices give 01 (draw).
  - Rock beats scissors, scissors beats paper, paper beats rock; the result is 10 or 11.
  - The result is registered into matchresult at the edge leaving JUDGE.
- REPORT, one cycle:
  - result_valid = 1 and matchresult holds the round result.
  - round_no, p1_wins and p2_wins already include this round.
  - Latency: second choice captured at edge N, result_valid high in the cycle after edge N+2.
- After REPORT:
  - If p1_wins or p2_wins == WIN_TARGET, go to GAMEOVER and set winner.
  - Otherwise go to COLLECT and clear the captured choices.
- Output idle values: outside REPORT, matchresult = 00 and result_valid = 0.
- Counter widths:
  - round_no is 4 bits and wraps 15 -> 0 on long draw streaks; wrapping has no effect on game logic.
  - Win counters never exceed WIN_TARGET.
- Draws increment round_no only; the round is replayed.
- GAMEOVER:
  - game_over = 1; winner and counters are held; both ready outputs are 0.
  - valid inputs are ignored.
  - start clears counters and winner and enters COLLECT.
- start outside IDLE/GAMEOVER means restart:
  - Clears captured choices and counters; next state is COLLECT.
  - No result_valid is produced for the aborted round.
  - If start coincides with the REPORT cycle, that strobe still appears and counters clear at the following edge.

Optional Feature:
- Macro: MATCH_JUDGE_TIMEOUT_EN
- Defined:
  - A TO_W-bit counter clears on entry to COLLECT and increments each COLLECT cycle.
  - When it reaches TIMEOUT_CYCLES with exactly one choice captured, the round goes to JUDGE as a forfeit: matchresult = 10 or 11 for the captured player, otherwise scored normally.
  - With neither choice captured, the counter restarts and there is no forfeit.
  - The counter is cleared by capture of the second choice, start, and reset.
- Undefined: COLLECT waits indefinitely; no counter logic is present.

Test Plan:
- Reset: hold resetn=0 with random inputs -> all outputs 0, ready low; release with start=0 -> state stays IDLE.
- Basic round: start, then p1=01 (rock) and p2=11 (scissors) in the same cycle -> after 2 more edges result_valid=1 for one cycle with matchresult=10, round_no=1, p1_wins=1; the following cycle shows matchresult=00.
- Draw and invalid choice:
  - p1 holds valid with choice 00 for 5 cycles -> p1_ready stays 1, nothing captured.
  - Then p1=10, p2=10 -> matchresult=01, round_no increments, wins unchanged.
  - A second p1 valid after capture is ignored.
- Game end (WIN_TARGET=3): p2 wins 3 rounds (paper vs rock) -> game_over=1, winner=10, p2_wins=3, ready low; valid inputs ignored; start -> counters 0, COLLECT.
- Abort paths:
  - start asserted after only p1 committed -> no result_valid, counters 0, both ready high.
  - resetn pulsed low during JUDGE -> immediate zero outputs, IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=1000): p1 commits, p2 silent -> forfeit result matchresult=10, p1_wins=1; with the macro undefined, the same stimulus produces no result after 5000 cycles.
